wave_capture_param: RTL and testbench

WAVE_CAPTURE_PARAM -- requirements
Module: wave_capture_param

---
 rtl/wave_pkg.sv | 23 ++
 rtl/wave_trig_detect.sv | 89 ++++++++
 rtl/wave_capture_param.sv | 108 ++++++++++
 tb/tb_wave_capture_param.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture block: FSM state encoding
// and the two's-complement to offset-binary sample conversion.
package wave_pkg;

  localparam logic [1:0] ARMED  = 2'b00;
  localparam logic [1:0] ACTIVE = 2'b01;
  localparam logic [1:0] WAIT   = 2'b10;

  // Widest sample the conversion helper accepts.
  localparam int OB_MAX_W = 64;

  // Keeps the top out_w bits of a sample_w-bit two's-complement value and
  // flips the sign bit, giving offset binary in bits [out_w-1:0]. The
  // caller zero-extends the sample to OB_MAX_W and truncates the result.
  function automatic logic [OB_MAX_W-1:0] offset_binary(
    input logic [OB_MAX_W-1:0] sample,
    input int                  sample_w,
    input int                  out_w
  );
    offset_binary = (sample >> (sample_w - out_w)) ^ (OB_MAX_W'(1) << (out_w - 1));
  endfunction

endpackage

// File: rtl/wave_trig_detect.sv
// Trigger detector: previous-sample tracking, signed level compare with
// rising/falling edge select, and the optional auto-trigger timeout.
// Macro WAVE_CAPTURE_AUTO_TRIG_EN enables the timeout path; without it the
// trigger comes from an edge only and auto_flag is tied low.
module wave_trig_detect
  import wave_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_strobe,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_falling,
  input  logic                arm_enable,
  output logic                trig,
  output logic                auto_flag
);

  logic [SAMPLE_W-1:0] prev_reg;
  logic                prev_valid_reg;
  logic                rise_hit;
  logic                fall_hit;
  logic                edge_hit;

  // Previous sample follows every strobe regardless of capture state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
    end else if (sample_strobe) begin
      prev_reg       <= sample;
      prev_valid_reg <= 1'b1;
    end
  end

  assign rise_hit = ($signed(prev_reg) <  $signed(trig_level)) &&
                    ($signed(sample)   >= $signed(trig_level));
  assign fall_hit = ($signed(prev_reg) >= $signed(trig_level)) &&
                    ($signed(sample)   <  $signed(trig_level));

  // Level and edge select only matter while armed, so changes made during
  // a capture take effect at the next arm.
  assign edge_hit = sample_strobe && arm_enable && prev_valid_reg &&
                    (trig_falling ? fall_hit : rise_hit);

`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT) + 1;

  logic [TO_W-1:0] timeout_reg;
  logic            timeout_hit;
  logic            auto_reg;

  assign timeout_hit = sample_strobe && arm_enable &&
                       (timeout_reg == TO_W'(AUTO_TIMEOUT - 1));

  // Counts strobes while armed; held at zero otherwise so it starts fresh
  // on each entry to ARMED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_reg <= '0;
    end else if (!arm_enable) begin
      timeout_reg <= '0;
    end else if (sample_strobe) begin
      timeout_reg <= timeout_reg + TO_W'(1);
    end
  end

  // Remembers whether the latest capture was forced; a real edge wins a tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_reg <= 1'b0;
    end else if (edge_hit) begin
      auto_reg <= 1'b0;
    end else if (timeout_hit) begin
      auto_reg <= 1'b1;
    end
  end

  assign trig      = edge_hit || timeout_hit;
  assign auto_flag = auto_reg;
`else
  assign trig      = edge_hit;
  assign auto_flag = 1'b0;
`endif

endmodule

// File: rtl/wave_capture_param.sv
// Waveform capture into a double-buffered RAM: waits armed for a trigger,
// writes 2^ADDR_W offset-binary samples into the half the display does not
// own, then waits for the display to go idle and swaps halves.
// Macro WAVE_CAPTURE_AUTO_TRIG_EN enables the auto-trigger timeout.
module wave_capture_param
  import wave_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int OUT_W        = 8,
  parameter int ADDR_W       = 8,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_falling,
  input  logic                wave_display_idle,
  output logic [ADDR_W:0]     write_address,
  output logic                write_enable,
  output logic [OUT_W-1:0]    write_sample,
  output logic                read_index,
  output logic                armed,
  output logic                triggered_auto
);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] count_reg;
  logic              read_index_reg;
  logic              write_enable_reg;
  logic [ADDR_W:0]   write_address_reg;
  logic [OUT_W-1:0]  write_sample_reg;
  logic              trig;
  logic              auto_flag;
  logic [OUT_W-1:0]  sample_ob;

  assign armed     = (state_reg == ARMED);
  assign sample_ob = OUT_W'(offset_binary(OB_MAX_W'(new_sample_in), SAMPLE_W, OUT_W));

  wave_trig_detect #(
    .SAMPLE_W     (SAMPLE_W),
    .AUTO_TIMEOUT (AUTO_TIMEOUT)
  ) u_trig (
    .clk           (clk),
    .reset         (reset),
    .sample_strobe (new_sample_ready),
    .sample        (new_sample_in),
    .trig_level    (trig_level),
    .trig_falling  (trig_falling),
    .arm_enable    (armed),
    .trig          (trig),
    .auto_flag     (auto_flag)
  );

  // Capture FSM plus registered write port; address/data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= ARMED;
      count_reg         <= '0;
      read_index_reg    <= 1'b0;
      write_enable_reg  <= 1'b0;
      write_address_reg <= '0;
      write_sample_reg  <= '0;
    end else begin
      write_enable_reg <= 1'b0;
      case (state_reg)
        ARMED: begin
          // The triggering sample itself becomes index 0.
          if (trig) begin
            state_reg         <= ACTIVE;
            count_reg         <= ADDR_W'(1);
            write_enable_reg  <= 1'b1;
            write_address_reg <= {~read_index_reg, {ADDR_W{1'b0}}};
            write_sample_reg  <= sample_ob;
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            write_enable_reg  <= 1'b1;
            write_address_reg <= {~read_index_reg, count_reg};
            write_sample_reg  <= sample_ob;
            if (count_reg == {ADDR_W{1'b1}}) begin
              state_reg <= WAIT;
              count_reg <= '0;
            end else begin
              count_reg <= count_reg + ADDR_W'(1);
            end
          end
        end
        WAIT: begin
          if (wave_display_idle) begin
            state_reg      <= ARMED;
            read_index_reg <= ~read_index_reg;
          end
        end
        default: state_reg <= ARMED;
      endcase
    end
  end

  assign write_enable   = write_enable_reg;
  assign write_address  = write_address_reg;
  assign write_sample   = write_sample_reg;
  assign read_index     = read_index_reg;
  assign triggered_auto = auto_flag;

endmodule

// File: tb/tb_wave_capture_param.sv
// Self-checking bench for wave_capture_param: trigger vector table plus
// hand-written capture, handover, reset and auto-trigger sequences, with a
// write scoreboard checked by a monitor.
module tb_wave_capture_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic [15:0] trig_level;
  logic        trig_falling;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  logic        armed;
  logic        triggered_auto;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic        falling;
    logic [15:0] level;
    logic [15:0] s0;
    logic [15:0] s1;
    logic        trig;
    logic [7:0]  data;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[10];
  logic exp_ri;

  always #5 clk = ~clk;

  wave_capture_param #(
    .SAMPLE_W     (16),
    .OUT_W        (8),
    .ADDR_W       (8),
    .AUTO_TIMEOUT (1024)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .trig_level        (trig_level),
    .trig_falling      (trig_falling),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index),
    .armed             (armed),
    .triggered_auto    (triggered_auto)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_ob(input logic [15:0] s);
    return {~s[15], s[14:8]};
  endfunction

  // Every write the DUT makes must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                 write_address, write_sample);
      end else begin
        e = exp_q.pop_front();
        check("write_address", 32'(write_address), 32'(e.addr));
        check("write_sample", 32'(write_sample), 32'(e.data));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    new_sample_ready = 1'b0;
    wave_display_idle = 1'b0;
    exp_ri = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] s, input bit wr, input logic [8:0] addr,
                        input logic [7:0] data);
    @(negedge clk);
    new_sample_in = s;
    new_sample_ready = 1'b1;
    if (wr) exp_q.push_back('{addr: addr, data: data});
    @(negedge clk);
    new_sample_ready = 1'b0;
  endtask

  task automatic capture_rest(input int start_idx, input int n);
    logic [15:0] s;
    for (int i = 0; i < n; i++) begin
      s = 16'((start_idx + i) * 97 - 12000);
      strobe(s, 1'b1, {~exp_ri, 8'(start_idx + i)}, exp_ob(s));
    end
  endtask

  // Any expected write still queued one cycle later was never produced.
  task automatic drain(input string name);
    @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic idle_pulse();
    @(negedge clk);
    wave_display_idle = 1'b1;
    @(negedge clk);
    wave_display_idle = 1'b0;
    exp_ri = ~exp_ri;
  endtask

  initial begin : main
    reset = 1'b1;
    new_sample_ready = 1'b0;
    new_sample_in = '0;
    trig_level = '0;
    trig_falling = 1'b0;
    wave_display_idle = 1'b0;
    exp_ri = 1'b0;

    //           falling level     s0        s1        trig  data
    vecs[0] = '{1'b0, 16'h0000, 16'hFF9C, 16'h0032, 1'b1, 8'h80};
    vecs[1] = '{1'b0, 16'h0000, 16'h0032, 16'h003C, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 16'h0000, 16'hFF9C, 16'hFFFF, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 8'h80};
    vecs[4] = '{1'b1, 16'h0100, 16'h0200, 16'h00FF, 1'b1, 8'h80};
    vecs[5] = '{1'b0, 16'h0100, 16'h0200, 16'h00FF, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 16'h0100, 16'h0100, 16'h00FF, 1'b1, 8'h80};
    vecs[7] = '{1'b1, 16'h0000, 16'h7FFF, 16'h8000, 1'b1, 8'h00};
    vecs[8] = '{1'b0, 16'h8000, 16'h8000, 16'h7FFF, 1'b0, 8'h00};
    vecs[9] = '{1'b0, 16'hFF00, 16'hFE00, 16'h1234, 1'b1, 8'h92};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_write_enable", 32'(write_enable), 32'd0);
    check("rst_write_address", 32'(write_address), 32'd0);
    check("rst_write_sample", 32'(write_sample), 32'd0);
    check("rst_read_index", 32'(read_index), 32'd0);
    check("rst_armed", 32'(armed), 32'd1);
    check("rst_triggered_auto", 32'(triggered_auto), 32'd0);
    reset = 1'b0;
    $display("[TB] reset state checked");

    // Trigger vector table
    for (int i = 0; i < 10; i++) begin
      do_reset();
      trig_falling = vecs[i].falling;
      trig_level = vecs[i].level;
      strobe(vecs[i].s0, 1'b0, 9'h000, 8'h00);
      strobe(vecs[i].s1, vecs[i].trig, 9'h100, vecs[i].data);
      check("vec_armed", 32'(armed), 32'(!vecs[i].trig));
      drain("vec_write_seen");
      $display("[TB] vector %0d: falling=%0d level=%h %h->%h trig=%0d",
               i, vecs[i].falling, vecs[i].level, vecs[i].s0, vecs[i].s1, vecs[i].trig);
    end

    // First strobe after reset never triggers
    do_reset();
    trig_falling = 1'b0;
    trig_level = 16'h0010;
    strobe(16'h0020, 1'b0, 9'h000, 8'h00);
    check("prev_valid_armed", 32'(armed), 32'd1);
    strobe(16'h0005, 1'b0, 9'h000, 8'h00);
    strobe(16'h0030, 1'b1, 9'h100, 8'h80);
    check("prev_valid_trig", 32'(armed), 32'd0);
    drain("prev_valid_write");
    $display("[TB] prev_valid sequence done");

    // Full capture, display idle ignored while active, WAIT strobes, handover
    do_reset();
    trig_falling = 1'b0;
    trig_level = 16'h0000;
    strobe(16'hFF9C, 1'b0, 9'h000, 8'h00);
    strobe(16'h0032, 1'b1, 9'h100, 8'h80);
    capture_rest(1, 100);
    wave_display_idle = 1'b1;
    capture_rest(101, 20);
    wave_display_idle = 1'b0;
    capture_rest(121, 135);
    check("cap1_armed", 32'(armed), 32'd0);
    check("cap1_read_index", 32'(read_index), 32'd0);
    drain("cap1_writes");
    strobe(16'hFF00, 1'b0, 9'h000, 8'h00);
    strobe(16'h0040, 1'b0, 9'h000, 8'h00);
    check("wait_armed", 32'(armed), 32'd0);
    drain("wait_no_write");
    idle_pulse();
    check("handover_read_index", 32'(read_index), 32'd1);
    check("handover_armed", 32'(armed), 32'd1);
    strobe(16'hFFFB, 1'b0, 9'h000, 8'h00);
    strobe(16'h0005, 1'b1, 9'h000, 8'h80);
    capture_rest(1, 255);
    check("cap2_armed", 32'(armed), 32'd0);
    check("cap2_read_index", 32'(read_index), 32'd1);
    drain("cap2_writes");
    $display("[TB] capture/handover sequence done");

    // Asynchronous reset in the middle of a capture
    do_reset();
    trig_falling = 1'b0;
    trig_level = 16'h0000;
    strobe(16'hFF9C, 1'b0, 9'h000, 8'h00);
    strobe(16'h0032, 1'b1, 9'h100, 8'h80);
    capture_rest(1, 100);
    #2 reset = 1'b1;
    #1;
    check("midrst_write_enable", 32'(write_enable), 32'd0);
    check("midrst_write_address", 32'(write_address), 32'd0);
    check("midrst_write_sample", 32'(write_sample), 32'd0);
    check("midrst_read_index", 32'(read_index), 32'd0);
    check("midrst_armed", 32'(armed), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    exp_ri = 1'b0;
    drain("midrst_queue");
    strobe(16'h000A, 1'b0, 9'h000, 8'h00);
    strobe(16'h0014, 1'b0, 9'h000, 8'h00);
    strobe(16'h001E, 1'b0, 9'h000, 8'h00);
    check("midrst_still_armed", 32'(armed), 32'd1);
    drain("midrst_no_write");
    strobe(16'hFFF0, 1'b0, 9'h000, 8'h00);
    strobe(16'h0001, 1'b1, 9'h100, 8'h80);
    check("midrst_retrig", 32'(armed), 32'd0);
    drain("midrst_retrig_write");
    $display("[TB] mid-capture reset sequence done");

    // Auto-trigger on a flat signal
    do_reset();
    trig_falling = 1'b0;
    trig_level = 16'h0000;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    repeat (1023) strobe(16'h0100, 1'b0, 9'h000, 8'h00);
    check("auto_pre_armed", 32'(armed), 32'd1);
    check("auto_pre_flag", 32'(triggered_auto), 32'd0);
    strobe(16'h0100, 1'b1, 9'h100, 8'h81);
    check("auto_armed", 32'(armed), 32'd0);
    check("auto_flag", 32'(triggered_auto), 32'd1);
    capture_rest(1, 255);
    drain("auto_writes");
    idle_pulse();
    strobe(16'hFF9C, 1'b0, 9'h000, 8'h00);
    strobe(16'h0032, 1'b1, 9'h000, 8'h80);
    check("auto_cleared_by_edge", 32'(triggered_auto), 32'd0);
    drain("auto_edge_write");
`else
    repeat (1100) strobe(16'h0100, 1'b0, 9'h000, 8'h00);
    check("noauto_armed", 32'(armed), 32'd1);
    check("noauto_flag", 32'(triggered_auto), 32'd0);
    drain("noauto_no_write");
`endif
    $display("[TB] auto-trigger sequence done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
